lights_monitor: RTL and testbench
=================================

Name: lights_monitor

Overview:
- Downstream checker that consumes the red/amber/green outputs of the traffic-light controller (`lights`) on the same clock.
- Decodes each sample into a phase and enforces the legal UK sequence R -> R+A -> G -> A -> R.
- Enforces a maximum dwell time per phase, counts completed light cycles, and raises a sticky error with a code.
- Sits beside `lights` in the top level and feeds status to the bench or to a debug LED.

Parameters:
- MAX_DWELL, default 8: maximum consecutive cycles any single phase may be held. Legal range 1..255.
- CNT_W, default 8: width of the completed-cycle counter.

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- red  input  1  red lamp from `lights`.
- amber  input  1  amber lamp from `lights`.
- green  input  1  green lamp from `lights`.
- phase  output  2  decoded phase, registered: 0=R, 1=RA, 2=G, 3=A.
- locked  output  1  high once the first legal pattern is accepted after reset.
- err  output  1  sticky error flag.
- err_code  output  2  first error cause: 0=none, 1=illegal pattern, 2=illegal transition, 3=dwell overrun.
- cycle_count  output  CNT_W  number of completed A->R transitions; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a rising edge) sets: phase=0, locked=0, err=0, err_code=0, cycle_count=0, internal dwell counter=0, FSM=SYNC.
- Reset mid-operation clears all state the same way on that edge; there is no partial retention.
- Pattern decode, {red,amber,green}:
  - 100 -> R
  - 110 -> RA
  - 001 -> G
  - 010 -> A
  - 000, 011, 101, 111 -> illegal.
- FSM states: SYNC, TRACK, FAULT.
- SYNC:
  - Legal pattern: go to TRACK next edge, phase=decoded value, locked=1, dwell=1.
  - Illegal pattern: stay in SYNC with no error. Power-up garbage is tolerated before lock.
- TRACK, evaluated each edge, priority highest first:
  - (1) Illegal pattern -> err_code=1.
  - (2) Decoded phase is neither the current phase nor its successor (R->RA->G->A->R) -> err_code=2.
  - (3) Same phase and dwell==MAX_DWELL -> err_code=3. The sample that would make dwell MAX_DWELL+1 is the overrun.
  - Any error sets err=1 and moves the FSM to FAULT.
  - Otherwise, successor phase: phase updates and dwell=1.
  - Otherwise, same phase: dwell+1.
  - Transition A->R also increments cycle_count, saturating at 2^CNT_W-1 with no wrap.
- FAULT:
  - err and err_code hold; later errors never overwrite the first code.
  - phase, dwell and cycle_count freeze.
  - Only rst leaves FAULT.
- Latency: all outputs are registered and reflect the sample taken on the previous rising edge (1-cycle latency).
- No combinational path from inputs to outputs.
- The dwell counter is 8 bits wide and cannot wrap, because overrun triggers at MAX_DWELL.

Test Plan:
- rst=1 for 2 edges, then release with inputs 000 for 3 cycles -> locked=0, err=0, err_code=0, phase=0.
- Legal sequence 100,110,001,010 repeated 3 times, one cycle each -> locked=1 after the first edge, err=0, cycle_count=2 after the second A->R and 3 after the third.
- Locked in G (001), then drive 100 -> one cycle later err=1, err_code=2; then drive 111 -> err_code stays 2.
- Locked in R, then drive 101 -> err=1, err_code=1; phase and cycle_count unchanged.
- MAX_DWELL=8, hold 100 for 8 cycles after lock -> err=0; hold a 9th cycle -> err=1, err_code=3.
- Assert rst in FAULT with cycle_count=3 -> next edge err=0, err_code=0, cycle_count=0, locked=0; then a legal sequence relocks.

Source files
------------

// File: rtl/lights_monitor.sv
// rtl/lights_monitor.sv - checker for the red/amber/green outputs of the traffic-light controller
//
// Purpose:
//   Decodes each {red,amber,green} sample into a phase and follows the UK
//   sequence R -> R+A -> G -> A -> R. It locks on the first legal pattern after
//   reset, bounds how long any phase may be held, and counts completed light
//   cycles (A -> R transitions). The first fault is latched with a cause code
//   until the next reset.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous active-high reset
//   red          in   1      red lamp
//   amber        in   1      amber lamp
//   green        in   1      green lamp
//   phase        out  2      decoded phase: 0=R 1=RA 2=G 3=A
//   locked       out  1      a legal pattern has been accepted since reset
//   err          out  1      sticky error flag
//   err_code     out  2      first cause: 0=none 1=pattern 2=transition 3=dwell
//   cycle_count  out  CNT_W  completed A->R transitions, saturating

module lights_monitor #(
  parameter int MAX_DWELL = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_RA = 2'd1;
  localparam logic [1:0] PH_G  = 2'd2;
  localparam logic [1:0] PH_A  = 2'd3;

  localparam logic [1:0] EC_NONE    = 2'd0;
  localparam logic [1:0] EC_PATTERN = 2'd1;
  localparam logic [1:0] EC_TRANS   = 2'd2;
  localparam logic [1:0] EC_DWELL   = 2'd3;

  localparam logic [7:0]       DWELL_LIMIT = 8'(MAX_DWELL);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  // Registered state
  logic [1:0]       r_state;
  logic [1:0]       r_phase;
  logic             r_locked;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [7:0]       r_dwell;
  logic [CNT_W-1:0] r_cycle_count;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_phase_nxt;
  logic             w_locked_nxt;
  logic             w_err_nxt;
  logic [1:0]       w_err_code_nxt;
  logic [7:0]       w_dwell_nxt;
  logic [CNT_W-1:0] w_cycle_count_nxt;

  // Pattern decode
  logic       w_legal;
  logic [1:0] w_dec;

  always_comb begin
    w_legal = 1'b1;
    w_dec   = PH_R;
    case ({red, amber, green})
      3'b100:  w_dec = PH_R;
      3'b110:  w_dec = PH_RA;
      3'b001:  w_dec = PH_G;
      3'b010:  w_dec = PH_A;
      default: w_legal = 1'b0;
    endcase
  end

  // The successor relation is a modulo-4 increment of the phase code, so
  // A (3) naturally wraps to R (0).
  logic w_same;
  logic w_succ;
  logic w_wrap;
  logic w_dwell_full;

  always_comb begin
    w_same       = (w_dec == r_phase);
    w_succ       = (w_dec == (r_phase + 2'd1));
    w_wrap       = (r_phase == PH_A) && (w_dec == PH_R);
    w_dwell_full = (r_dwell == DWELL_LIMIT);
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_locked_nxt      = r_locked;
    w_err_nxt         = r_err;
    w_err_code_nxt    = r_err_code;
    w_dwell_nxt       = r_dwell;
    w_cycle_count_nxt = r_cycle_count;

    case (r_state)
      ST_SYNC: begin
        // Garbage before the first legal pattern is ignored silently.
        if (w_legal) begin
          w_state_nxt  = ST_TRACK;
          w_phase_nxt  = w_dec;
          w_locked_nxt = 1'b1;
          w_dwell_nxt  = 8'd1;
        end
      end

      ST_TRACK: begin
        if (!w_legal) begin
          w_state_nxt    = ST_FAULT;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = EC_PATTERN;
        end else if (!w_same && !w_succ) begin
          w_state_nxt    = ST_FAULT;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = EC_TRANS;
        end else if (w_same) begin
          // Holding the phase once more while already at the limit is the
          // overrun; the counter therefore never exceeds MAX_DWELL.
          if (w_dwell_full) begin
            w_state_nxt    = ST_FAULT;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = EC_DWELL;
          end else begin
            w_dwell_nxt = r_dwell + 8'd1;
          end
        end else begin
          w_phase_nxt = w_dec;
          w_dwell_nxt = 8'd1;
          if (w_wrap && (r_cycle_count != CNT_SAT)) begin
            w_cycle_count_nxt = r_cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      ST_FAULT: begin
        // Everything frozen; only reset leaves this state.
      end

      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_SYNC;
      r_phase       <= PH_R;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= EC_NONE;
      r_dwell       <= 8'd0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_locked      <= w_locked_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
      r_dwell       <= w_dwell_nxt;
      r_cycle_count <= w_cycle_count_nxt;
    end
  end

  assign phase       = r_phase;
  assign locked      = r_locked;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_lights_monitor.sv
// tb/tb_lights_monitor.sv - self-checking bench for lights_monitor

module tb_lights_monitor;

  localparam int MAX_DWELL = 8;
  localparam int CNT_W     = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             red = 1'b0;
  logic             amber = 1'b0;
  logic             green = 1'b0;
  logic [1:0]       phase;
  logic             locked;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;

  lights_monitor #(
    .MAX_DWELL (MAX_DWELL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .red         (red),
    .amber       (amber),
    .green       (green),
    .phase       (phase),
    .locked      (locked),
    .err         (err),
    .err_code    (err_code),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: lamp pattern -> index in the ring R,RA,G,A, or -1.
  int m_phase, m_dwell, m_count, m_code;
  bit m_locked, m_err;

  function automatic int decode(input logic [2:0] p);
    case (p)
      3'b100:  return 0;
      3'b110:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_edge(input bit r, input logic [2:0] p);
    int d;
    d = decode(p);
    if (r) begin
      m_phase = 0; m_dwell = 0; m_count = 0; m_code = 0;
      m_locked = 0; m_err = 0;
    end else if (!m_locked) begin
      if (d >= 0) begin
        m_locked = 1; m_phase = d; m_dwell = 1;
      end
    end else if (!m_err) begin
      if (d < 0) begin
        m_err = 1; m_code = 1;
      end else if (d != m_phase && d != (m_phase + 1) % 4) begin
        m_err = 1; m_code = 2;
      end else if (d == m_phase) begin
        if (m_dwell == MAX_DWELL) begin
          m_err = 1; m_code = 3;
        end else begin
          m_dwell++;
        end
      end else begin
        if (m_phase == 3 && m_count < CNT_MAX) m_count++;
        m_phase = d; m_dwell = 1;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase",       int'(phase),       m_phase);
      check("locked",      int'(locked),      int'(m_locked));
      check("err",         int'(err),         int'(m_err));
      check("err_code",    int'(err_code),    m_code);
      check("cycle_count", int'(cycle_count), m_count);
    end
  end

  task automatic step(input bit r, input logic [2:0] p);
    rst = r;
    {red, amber, green} = p;
    @(posedge clk);
    model_edge(r, p);
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic full_cycle();
    step(0, 3'b100); step(0, 3'b110); step(0, 3'b001); step(0, 3'b010);
  endtask

  initial begin
    // Reset for two edges, then garbage that must not lock.
    step(1, 3'b000);
    step(1, 3'b000);
    check("rst_phase",  int'(phase), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err",    int'(err), 0);
    check("rst_code",   int'(err_code), 0);
    check("rst_count",  int'(cycle_count), 0);
    repeat (3) step(0, 3'b000);
    check("sync_locked", int'(locked), 0);
    check("sync_err",    int'(err), 0);
    check("sync_phase",  int'(phase), 0);

    // Three legal cycles; the final R completes the third A->R.
    step(0, 3'b100);
    check("lock_now", int'(locked), 1);
    step(0, 3'b110); step(0, 3'b001); step(0, 3'b010);
    full_cycle();
    full_cycle();
    check("count_2", int'(cycle_count), 2);
    step(0, 3'b100);
    check("count_3", int'(cycle_count), 3);
    check("seq_err", int'(err), 0);

    // G followed by R is a skipped phase; later garbage keeps code 2.
    step(0, 3'b110); step(0, 3'b001);
    step(0, 3'b100);
    check("skip_err",   int'(err), 1);
    check("skip_code",  int'(err_code), 2);
    check("skip_phase", int'(phase), 2);
    step(0, 3'b111);
    check("sticky_code", int'(err_code), 2);

    // Reset in FAULT with count 3, then relock.
    check("pre_rst_count", int'(cycle_count), 3);
    step(1, 3'b010);
    check("frst_err",    int'(err), 0);
    check("frst_code",   int'(err_code), 0);
    check("frst_count",  int'(cycle_count), 0);
    check("frst_locked", int'(locked), 0);
    step(0, 3'b100);
    check("relock", int'(locked), 1);

    // Illegal pattern from R.
    step(0, 3'b101);
    check("pat_err",   int'(err), 1);
    check("pat_code",  int'(err_code), 1);
    check("pat_phase", int'(phase), 0);
    check("pat_count", int'(cycle_count), 0);

    // Dwell: eight samples of R are allowed, the ninth is the overrun.
    step(1, 3'b000);
    repeat (MAX_DWELL) step(0, 3'b100);
    check("dwell_ok", int'(err), 0);
    step(0, 3'b100);
    check("dwell_err",  int'(err), 1);
    check("dwell_code", int'(err_code), 3);

    // Counter saturation, then an A->RA jump.
    step(1, 3'b000);
    step(0, 3'b100);
    repeat (CNT_MAX + 2) begin
      step(0, 3'b110); step(0, 3'b001); step(0, 3'b010); step(0, 3'b100);
    end
    check("sat_count", int'(cycle_count), CNT_MAX);
    check("sat_err",   int'(err), 0);
    step(0, 3'b110); step(0, 3'b001); step(0, 3'b010);
    step(0, 3'b110);
    check("a_ra_code", int'(err_code), 2);
    check("a_ra_count", int'(cycle_count), CNT_MAX);

    // Mid-run reset, garbage, lock in G, dwell overrun in A.
    step(1, 3'b001);
    step(0, 3'b111);
    check("garb_locked", int'(locked), 0);
    step(0, 3'b001);
    check("g_lock_phase", int'(phase), 2);
    repeat (MAX_DWELL) step(0, 3'b010);
    check("a_dwell_ok", int'(err), 0);
    step(0, 3'b010);
    check("a_dwell_code", int'(err_code), 3);
    check("a_dwell_phase", int'(phase), 3);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
